// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises raw lines, latches edge/level events into PENDING,
// masks with ENABLE to drive irq_o. Optional drop counter under `IRQ_CTRL_DROPCNT_EN.
module irq_ctrl #(
  parameter int          NUM_IRQ     = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] LEVEL_MASK  = 32'h0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_IRQ-1:0] irq_raw,
  output logic [NUM_IRQ-1:0] irq_o,
  input  logic [NUM_IRQ-1:0] eoi,
  input  logic               bus_valid,
  input  logic [3:0]         bus_addr,
  input  logic [3:0]         bus_wstrb,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ready
);

  typedef enum logic [3:0] {
    A_PENDING = 4'h0,
    A_ENABLE  = 4'h4,
    A_RAW     = 4'h8,
    A_DROPCNT = 4'hC
  } addr_e;

  localparam logic [NUM_IRQ-1:0] LEVEL = LEVEL_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_irq;
  logic               r_ready;
  logic [31:0]        r_rdata;

  logic [NUM_IRQ-1:0] w_s;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_bitmask;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_enable_nxt;
  logic [31:0]        w_bytemask;
  logic [31:0]        w_rdmux;
  logic               w_accept;
  logic               w_wr;
  logic               w_rd;
  logic               w_unused;

  assign w_s   = r_sync[SYNC_STAGES-1];
  assign w_set = (w_s & ~r_prev & ~LEVEL) | (w_s & LEVEL);

  // An access is taken only while ready is low, so each transfer costs two cycles.
  assign w_accept   = bus_valid & ~r_ready;
  assign w_wr       = w_accept & (|bus_wstrb);
  assign w_rd       = w_accept & ~(|bus_wstrb);
  assign w_bytemask = {{8{bus_wstrb[3]}}, {8{bus_wstrb[2]}}, {8{bus_wstrb[1]}}, {8{bus_wstrb[0]}}};
  assign w_bitmask  = w_bytemask[NUM_IRQ-1:0];
  assign w_wdata    = bus_wdata[NUM_IRQ-1:0];
  assign w_unused   = ^{bus_wdata, w_bytemask};

  assign w_w1c        = (w_wr && bus_addr == A_PENDING) ? (w_bitmask & w_wdata) : '0;
  assign w_clr        = eoi | w_w1c;
  assign w_enable_nxt = (w_wr && bus_addr == A_ENABLE)
                      ? ((r_enable & ~w_bitmask) | (w_wdata & w_bitmask)) : r_enable;

`ifdef IRQ_CTRL_DROPCNT_EN
  logic [15:0] r_dropcnt;
  logic        w_drop;
  logic        w_cnt_clr;

  // A lost edge: an edge source fires again before its previous event was retired.
  assign w_drop    = |(w_set & ~LEVEL & r_pending & ~w_clr);
  assign w_cnt_clr = w_wr && bus_addr == A_DROPCNT;

  always_ff @(posedge clk) begin
    if (!rstn)                              r_dropcnt <= '0;
    else if (w_cnt_clr)                     r_dropcnt <= '0;
    else if (w_drop && r_dropcnt != 16'hFFFF) r_dropcnt <= r_dropcnt + 16'd1;
  end
`endif

  always_comb begin
    w_rdmux = '0;
    case (bus_addr)
      A_PENDING: w_rdmux = 32'(r_pending);
      A_ENABLE:  w_rdmux = 32'(r_enable);
      A_RAW:     w_rdmux = 32'(w_s);
`ifdef IRQ_CTRL_DROPCNT_EN
      A_DROPCNT: w_rdmux = {16'h0, r_dropcnt};
`endif
      default:   w_rdmux = '0;
    endcase
  end

  // NOTE: every flop here, including the synchroniser chain, is cleared by the
  // synchronous reset; state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev    <= '0;
      r_pending <= '0;
      r_enable  <= '0;
      r_irq     <= '0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_sync[0] <= irq_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev    <= w_s;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_enable  <= w_enable_nxt;
      r_irq     <= r_pending & r_enable;
      r_ready   <= w_accept;
      r_rdata   <= w_rd ? w_rdmux : '0;
    end
  end

  assign irq_o     = r_irq;
  assign bus_ready = r_ready;
  assign bus_rdata = r_rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: bus reads go through an expected-value scoreboard,
// irq_o is checked at fixed latencies. Build with +define+IRQ_CTRL_DROPCNT_EN for the counter.
module tb_irq_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] irq_raw;
  logic [15:0] irq_o;
  logic [15:0] eoi;
  logic        bus_valid;
  logic [3:0]  bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  int  n_vec = 0;
  int  n_err = 0;
  sb_t sb_q[$];

`ifdef IRQ_CTRL_DROPCNT_EN
  localparam logic [31:0] EXP_DROP = 32'd2;
`else
  localparam logic [31:0] EXP_DROP = 32'd0;
`endif

  irq_ctrl #(.NUM_IRQ(16), .SYNC_STAGES(2), .LEVEL_MASK(32'h2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .irq_raw   (irq_raw),
    .irq_o     (irq_o),
    .eoi       (eoi),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge two cycles later.
  task automatic bus(input logic [3:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                     input logic [31:0] exp, input string tag);
    int  waited;
    sb_t e;
    sb_q.push_back('{tag, exp});
    bus_valid = 1'b1;
    bus_addr  = addr;
    bus_wstrb = strb;
    bus_wdata = wd;
    waited    = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus_ready && waited < 4);
    e = sb_q.pop_front();
    if (bus_ready) check({e.tag, "_rdata"}, bus_rdata, e.exp);
    else           check({e.tag, "_timeout"}, 32'(bus_ready), 32'd1);
    bus_valid = 1'b0;
    bus_wstrb = '0;
    bus_wdata = '0;
    @(negedge clk);
    check({tag, "_ready_pulse"}, 32'(bus_ready), 32'd0);
    check({tag, "_rdata_idle"}, bus_rdata, 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; irq_raw = 16'hFFFF; eoi = '0;
    bus_valid = 1'b0; bus_addr = '0; bus_wstrb = '0; bus_wdata = '0;

    // Reset with all lines high: nothing may leak through.
    cycles(3);
    check("rst_irq_o", 32'(irq_o), 32'd0);
    check("rst_ready", 32'(bus_ready), 32'd0);
    rstn = 1'b1; irq_raw = '0;
    cycles(1);
    check("post_rst_irq_o", 32'(irq_o), 32'd0);
    bus(4'h0, 4'h0, '0, 32'h0, "rst_pending");
    bus(4'h4, 4'h0, '0, 32'h0, "rst_enable");
    bus(4'h8, 4'h0, '0, 32'h0, "rst_raw");
    bus(4'hC, 4'h0, '0, 32'h0, "rst_dropcnt");

    // Edge latency on source 0: irq_o at E0+3, clears two edges after eoi.
    bus(4'h4, 4'hF, 32'h1, 32'h0, "wr_en1");
    irq_raw[0] = 1'b1;
    cycles(3);
    check("edge_e0p2", 32'(irq_o), 32'h0);
    cycles(1);
    check("edge_e0p3", 32'(irq_o), 32'h1);
    eoi[0] = 1'b1;
    cycles(1);
    eoi[0] = 1'b0;
    check("eoi_x0", 32'(irq_o), 32'h1);
    cycles(1);
    check("eoi_x1", 32'(irq_o), 32'h0);
    cycles(4);
    check("no_retrigger", 32'(irq_o), 32'h0);
    bus(4'h0, 4'h0, '0, 32'h0, "pend_after_eoi");

    // Level source 1 re-asserts while the line is high.
    irq_raw[1] = 1'b1;
    cycles(4);
    eoi[1] = 1'b1;
    cycles(1);
    eoi[1] = 1'b0;
    cycles(1);
    bus(4'h0, 4'h0, '0, 32'h2, "level_held");
    irq_raw[1] = 1'b0;
    cycles(3);
    bus(4'h0, 4'h0, '0, 32'h2, "level_dropped");
    eoi[1] = 1'b1;
    cycles(1);
    eoi[1] = 1'b0;
    bus(4'h0, 4'h0, '0, 32'h0, "level_cleared");

    // Source 2: new edge lands in the same cycle as eoi[2]; set must win.
    irq_raw[2] = 1'b1;
    cycles(4);
    irq_raw[2] = 1'b0;
    cycles(3);
    irq_raw[2] = 1'b1;
    cycles(2);
    eoi[2] = 1'b1;
    cycles(1);
    eoi[2] = 1'b0;
    cycles(1);
    bus(4'h0, 4'h0, '0, 32'h4, "set_wins");

    // Byte strobes on ENABLE; upper bits read as zero.
    bus(4'h4, 4'b0001, 32'h0000_00F0, 32'h0, "wr_en_f0");
    bus(4'h4, 4'h0, '0, 32'h0000_00F0, "rd_en_f0");
    bus(4'h4, 4'b0010, 32'hFFFF_FF00, 32'h0, "wr_en_b1");
    bus(4'h4, 4'h0, '0, 32'h0000_FFF0, "rd_en_fff0");
    bus(4'h4, 4'b0010, 32'h0, 32'h0, "wr_en_b1_clr");

    // Disabled source 2 is pending but not driven; W1C clears only bit 4.
    irq_raw[5:4] = 2'b11;
    cycles(4);
    check("irq_mask", 32'(irq_o), 32'h0030);
    bus(4'h0, 4'h0, '0, 32'h34, "pend_34");
    bus(4'h0, 4'hF, 32'h10, 32'h0, "w1c_bit4");
    check("irq_after_w1c", 32'(irq_o), 32'h0020);
    bus(4'h0, 4'b0010, 32'h20, 32'h0, "w1c_wrong_byte");
    bus(4'h0, 4'h0, '0, 32'h24, "pend_24");
    bus(4'h4, 4'b0001, 32'hF4, 32'h0, "late_enable");
    check("irq_late_enable", 32'(irq_o), 32'h0024);
    bus(4'h2, 4'h0, '0, 32'h0, "unmapped");

    // Three edges on source 0 with no eoi: two are lost.
    irq_raw[0] = 1'b0;
    cycles(3);
    for (int k = 0; k < 3; k++) begin
      irq_raw[0] = 1'b1;
      cycles(3);
      irq_raw[0] = 1'b0;
      cycles(3);
    end
    bus(4'h0, 4'h0, '0, 32'h25, "pend_25");
    bus(4'hC, 4'h0, '0, EXP_DROP, "dropcnt");
    bus(4'hC, 4'hF, 32'h0, 32'h0, "dropcnt_clr");
    bus(4'hC, 4'h0, '0, 32'h0, "dropcnt_zero");

    // RAW tracks the synchronised lines.
    irq_raw = 16'h5A00;
    cycles(3);
    bus(4'h8, 4'h0, '0, 32'h0000_5A00, "raw_5a00");
    irq_raw = 16'h00C3;
    cycles(3);
    bus(4'h8, 4'h0, '0, 32'h0000_00C3, "raw_00c3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
